sequenciador_posicionamento: RTL and testbench

//  Placement controller for the fleet-setup phase. Walks each player through the 11-ship fleet in fixed order,

---
 rtl/sequenciador_posicionamento.sv | 167 ++++++++++++++++
 tb/tb_sequenciador_posicionamento.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_posicionamento.sv
// Fleet placement sequencer: steps both players through their ships, hands each
// confirmed placement to the validator and reacts to its verdict or a timeout.
module sequenciador_posicionamento #(
    parameter int N_PECAS     = 11,
    parameter int TIMEOUT     = 64,
    parameter int ERRO_CICLOS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       confirma,
    input  logic [3:0] x_in,
    input  logic [3:0] y_in,
    input  logic       direcao_in,
    input  logic [2:0] orientacao_in,
    input  logic       val_ready,
    input  logic       val_conflito,
    output logic       val_enable,
    output logic [2:0] val_tipo,
    output logic [3:0] val_x,
    output logic [3:0] val_y,
    output logic       val_direcao,
    output logic [2:0] val_orientacao,
    output logic       val_jogador,
    output logic [3:0] indice_peca,
    output logic       erro,
    output logic       ocupado,
    output logic       fim_posicionamento
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int EW = (ERRO_CICLOS > 1) ? $clog2(ERRO_CICLOS) : 1;

    localparam logic [2:0] ESPERA  = 3'd0;
    localparam logic [2:0] DISPARA = 3'd1;
    localparam logic [2:0] AGUARDA = 3'd2;
    localparam logic [2:0] ACEITA  = 3'd3;
    localparam logic [2:0] ERRO    = 3'd4;
    localparam logic [2:0] TROCA   = 3'd5;
    localparam logic [2:0] FIM     = 3'd6;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [TW-1:0] r_timer;
    logic [EW-1:0] r_erro_cnt;
    logic          r_confirma_q;
    logic          w_edge;
    logic          w_ultima;
    logic [3:0]    r_indice;
    logic          r_jogador;
    logic [3:0]    r_x;
    logic [3:0]    r_y;
    logic          r_dir;
    logic [2:0]    r_ori;
    logic          r_val_enable;
    logic          r_ocupado;
    logic          r_erro;
    logic          r_fim;

    // Fixed fleet order: one carrier, two battleships, three seaplanes, two cruisers, three submarines.
    function automatic logic [2:0] tipo_de(input logic [3:0] idx);
        logic [2:0] t;
        case (idx)
            4'd0:                t = 3'd0;
            4'd1, 4'd2:          t = 3'd1;
            4'd3, 4'd4, 4'd5:    t = 3'd2;
            4'd6, 4'd7:          t = 3'd3;
            default:             t = 3'd4;
        endcase
        return t;
    endfunction

    assign w_edge   = confirma & ~r_confirma_q;
    assign w_ultima = (r_indice == 4'(N_PECAS - 1));

    // Next-state selection; a conflict outranks a simultaneous ready.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ESPERA: begin
                if (w_edge) w_next = DISPARA;
                else        w_next = ESPERA;
            end
            DISPARA: w_next = AGUARDA;
            AGUARDA: begin
                if (val_conflito)                      w_next = ERRO;
                else if (val_ready)                    w_next = ACEITA;
                else if (r_timer == TW'(TIMEOUT - 1))  w_next = ERRO;
                else                                   w_next = AGUARDA;
            end
            ACEITA: begin
                if (w_ultima) w_next = r_jogador ? FIM : TROCA;
                else          w_next = ESPERA;
            end
            ERRO: begin
                if (r_erro_cnt == EW'(ERRO_CICLOS - 1)) w_next = ESPERA;
                else                                     w_next = ERRO;
            end
            TROCA:   w_next = ESPERA;
            FIM:     w_next = FIM;
            default: w_next = ESPERA;
        endcase
    end

    // State, placement datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ESPERA;
            r_timer      <= '0;
            r_erro_cnt   <= '0;
            r_confirma_q <= 1'b0;
            r_indice     <= 4'd0;
            r_jogador    <= 1'b0;
            r_x          <= 4'd0;
            r_y          <= 4'd0;
            r_dir        <= 1'b0;
            r_ori        <= 3'd0;
            r_val_enable <= 1'b0;
            r_ocupado    <= 1'b0;
            r_erro       <= 1'b0;
            r_fim        <= 1'b0;
        end else begin
            r_confirma_q <= confirma;
            r_state      <= w_next;
            r_val_enable <= (w_next == DISPARA);
            r_ocupado    <= (w_next == DISPARA) || (w_next == AGUARDA);
            r_erro       <= (w_next == ERRO);
            r_fim        <= (w_next == FIM);
            case (r_state)
                ESPERA: begin
                    if (w_edge) begin
                        r_x   <= x_in;
                        r_y   <= y_in;
                        r_dir <= direcao_in;
                        r_ori <= orientacao_in;
                    end
                end
                DISPARA: r_timer <= '0;
                AGUARDA: begin
                    r_timer    <= r_timer + TW'(1);
                    r_erro_cnt <= '0;
                end
                ACEITA: begin
                    if (!w_ultima) r_indice <= r_indice + 4'd1;
                end
                ERRO:   r_erro_cnt <= r_erro_cnt + EW'(1);
                TROCA: begin
                    r_indice  <= 4'd0;
                    r_jogador <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign val_enable         = r_val_enable;
    assign val_tipo           = tipo_de(r_indice);
    assign val_x              = r_x;
    assign val_y              = r_y;
    assign val_direcao        = r_dir;
    assign val_orientacao     = r_ori;
    assign val_jogador        = r_jogador;
    assign indice_peca        = r_indice;
    assign erro               = r_erro;
    assign ocupado            = r_ocupado;
    assign fim_posicionamento = r_fim;

endmodule

// File: tb/tb_sequenciador_posicionamento.sv
// Bench for the placement sequencer: directed scenarios plus random traffic, all
// compared each cycle against a counter-based model of the placement rules.
module tb_sequenciador_posicionamento;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       confirma;
    logic [3:0] x_in, y_in;
    logic       direcao_in;
    logic [2:0] orientacao_in;
    logic       val_ready, val_conflito;
    logic       val_enable;
    logic [2:0] val_tipo;
    logic [3:0] val_x, val_y;
    logic       val_direcao;
    logic [2:0] val_orientacao;
    logic       val_jogador;
    logic [3:0] indice_peca;
    logic       erro, ocupado, fim_posicionamento;

    sequenciador_posicionamento dut (
        .clk(clk), .rst_n(rst_n), .confirma(confirma),
        .x_in(x_in), .y_in(y_in), .direcao_in(direcao_in), .orientacao_in(orientacao_in),
        .val_ready(val_ready), .val_conflito(val_conflito),
        .val_enable(val_enable), .val_tipo(val_tipo), .val_x(val_x), .val_y(val_y),
        .val_direcao(val_direcao), .val_orientacao(val_orientacao),
        .val_jogador(val_jogador), .indice_peca(indice_peca),
        .erro(erro), .ocupado(ocupado), .fim_posicionamento(fim_posicionamento)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a placement is "firing", "waiting N cycles", "accepting", "in error for N cycles",
    // "swapping player" or nothing; idle means all of those are clear.
    bit m_prev, m_fire, m_accept, m_swap, m_done;
    int m_wait, m_err, m_idx, m_player, m_x, m_y, m_d, m_o;
    int en_count, erro_count;
    bit prev_en;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_fire = 0; m_accept = 0; m_swap = 0; m_done = 0;
        m_wait = -1; m_err = 0; m_idx = 0; m_player = 0;
        m_x = 0; m_y = 0; m_d = 0; m_o = 0;
    endtask

    task automatic model_update();
        bit edge_s;
        edge_s = confirma && !m_prev;
        m_prev = confirma;
        if (m_done) begin
        end else if (m_fire) begin
            m_fire = 0;
            m_wait = 0;
        end else if (m_wait >= 0) begin
            if (val_conflito) begin m_err = 8; m_wait = -1; end
            else if (val_ready) begin m_accept = 1; m_wait = -1; end
            else if (m_wait == 63) begin m_err = 8; m_wait = -1; end
            else m_wait++;
        end else if (m_accept) begin
            m_accept = 0;
            if (m_idx == 10) begin
                if (m_player == 0) m_swap = 1;
                else m_done = 1;
            end else m_idx++;
        end else if (m_err > 0) begin
            m_err--;
        end else if (m_swap) begin
            m_swap = 0; m_idx = 0; m_player = 1;
        end else if (edge_s) begin
            m_fire = 1;
            m_x = x_in; m_y = y_in; m_d = direcao_in; m_o = orientacao_in;
        end
    endtask

    function automatic int tipo_model(input int idx);
        if (idx < 1) return 0;
        if (idx < 3) return 1;
        if (idx < 6) return 2;
        if (idx < 8) return 3;
        return 4;
    endfunction

    task automatic compare_all();
        chk("val_enable", val_enable, m_fire);
        chk("ocupado", ocupado, (m_fire || m_wait >= 0) ? 1 : 0);
        chk("erro", erro, (m_err > 0) ? 1 : 0);
        chk("fim", fim_posicionamento, m_done);
        chk("indice", indice_peca, m_idx);
        chk("jogador", val_jogador, m_player);
        chk("tipo", val_tipo, tipo_model(m_idx));
        chk("val_x", val_x, m_x);
        chk("val_y", val_y, m_y);
        chk("val_dir", val_direcao, m_d);
        chk("val_ori", val_orientacao, m_o);
        chk("en_consecutive", (val_enable && prev_en) ? 1 : 0, 0);
        prev_en = val_enable;
        en_count += val_enable;
        erro_count += erro;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; confirma = 1'b0; val_ready = 1'b0; val_conflito = 1'b0;
        x_in = 4'd0; y_in = 4'd0; direcao_in = 1'b0; orientacao_in = 3'd0;
        model_reset();
        prev_en = 0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic place_ok(input int x, input int y, input int delay);
        x_in = 4'(x); y_in = 4'(y); direcao_in = 1'b0; orientacao_in = 3'(x % 4);
        confirma = 1'b1;
        step();
        confirma = 1'b0;
        repeat (delay) step();
        val_ready = 1'b1;
        step();
        val_ready = 1'b0;
        repeat (3) step();
    endtask

    int e0, r0;

    initial begin
        en_count = 0; erro_count = 0;
        do_reset();
        chk("rst_enable", val_enable, 0);
        chk("rst_indice", indice_peca, 0);
        chk("rst_jogador", val_jogador, 0);
        chk("rst_tipo", val_tipo, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_fim", fim_posicionamento, 0);
        step();

        // First placement, ready three cycles after the start pulse.
        e0 = en_count;
        x_in = 4'd2; y_in = 4'd3; direcao_in = 1'b0; orientacao_in = 3'd0;
        confirma = 1'b1;
        step();
        chk("lit_first_enable", val_enable, 1);
        confirma = 1'b0;
        x_in = 4'd9; y_in = 4'd9;
        repeat (3) step();
        val_ready = 1'b1;
        step();
        val_ready = 1'b0;
        repeat (3) step();
        chk("lit_pulses", en_count - e0, 1);
        chk("lit_x", val_x, 2);
        chk("lit_y", val_y, 3);
        chk("lit_indice1", indice_peca, 1);
        chk("lit_tipo1", val_tipo, 1);

        // Advance to index 5, then reject with conflict and ready together.
        for (int i = 0; i < 4; i++) place_ok(i, i + 1, 2);
        chk("lit_indice5", indice_peca, 5);
        r0 = erro_count;
        confirma = 1'b1;
        step();
        confirma = 1'b0;
        step();
        val_ready = 1'b1; val_conflito = 1'b1;
        step();
        val_ready = 1'b0; val_conflito = 1'b0;
        repeat (12) step();
        chk("lit_erro_cycles", erro_count - r0, 8);
        chk("lit_indice_retry", indice_peca, 5);
        place_ok(7, 7, 1);
        chk("lit_indice6", indice_peca, 6);

        // Validator never answers: timeout error, no extra pulse.
        e0 = en_count; r0 = erro_count;
        confirma = 1'b1;
        step();
        confirma = 1'b0;
        repeat (80) step();
        chk("lit_timeout_erro", erro_count - r0, 8);
        chk("lit_timeout_pulses", en_count - e0, 1);
        chk("lit_timeout_indice", indice_peca, 6);

        // Held confirm gives a single request.
        e0 = en_count;
        confirma = 1'b1;
        repeat (5) step();
        val_ready = 1'b1;
        step();
        val_ready = 1'b0;
        repeat (14) step();
        confirma = 1'b0;
        step();
        chk("lit_hold_pulses", en_count - e0, 1);
        chk("lit_hold_indice", indice_peca, 7);

        // Reset while waiting for a verdict.
        confirma = 1'b1;
        step();
        confirma = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("lit_midrst_ocupado", ocupado, 0);
        chk("lit_midrst_indice", indice_peca, 0);
        step();
        rst_n = 1'b1;
        step();

        // Two full fleets.
        for (int i = 0; i < 11; i++) place_ok(i % 10, 9 - (i % 10), 1 + (i % 3));
        chk("lit_jogador1", val_jogador, 1);
        chk("lit_indice_after_swap", indice_peca, 0);
        for (int i = 0; i < 11; i++) place_ok(i, i, 2);
        chk("lit_fim", fim_posicionamento, 1);
        e0 = en_count;
        for (int i = 0; i < 3; i++) begin
            confirma = 1'b1; step(); confirma = 1'b0; repeat (3) step();
        end
        chk("lit_fim_no_pulse", en_count - e0, 0);

        // Random traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) confirma = ~confirma;
            x_in = 4'($urandom_range(0, 15));
            y_in = 4'($urandom_range(0, 15));
            direcao_in = 1'($urandom_range(0, 1));
            orientacao_in = 3'($urandom_range(0, 3));
            val_ready = ($urandom_range(0, 7) == 0);
            val_conflito = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
